// File: rtl/scaler_pkg.sv
// Shared definitions for the image-scaling control unit.
package scaler_pkg;

    // Control unit sequencing states
    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } state_t;

    // Algorithm-select codes driven by the user switches
    localparam logic [1:0] ALG_COPY  = 2'b00;
    localparam logic [1:0] ALG_NN2X  = 2'b01;
    localparam logic [1:0] ALG_REP2X = 2'b10;
    localparam logic [1:0] ALG_RSVD  = 2'b11;

    // Frame geometry of the source and destination RAMs
    localparam int unsigned SRC_W  = 320;
    localparam int unsigned SRC_H  = 240;
    localparam int unsigned DEST_W = 640;
    localparam int unsigned DEST_H = 480;

    // True when the code selects an implemented algorithm
    function automatic logic alg_valid(input logic [1:0] alg);
        return alg != ALG_RSVD;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous pushbutton followed by a
// rising-edge detector; one pulse per press no matter how long it is held.
module btn_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronise the pin and keep the previous synchronised level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/scaler_uc.sv
// Sequencer for the scaling engine: accepts a start press, latches the
// algorithm, hands the destination RAM to the engine for one run and
// returns it to the VGA reader on completion or watchdog timeout.
module scaler_uc
    import scaler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 131072,
    parameter int unsigned CNT_W          = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic [1:0] alg_sel,
    input  logic       cpu_done,
    output logic       cpu_start,
    output logic [1:0] cpu_alg,
    output logic       busy,
    output logic       dest_owner,
    output logic       frame_valid,
    output logic       err_invalid,
    output logic       err_timeout
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cpu_start;
    logic [1:0]       r_cpu_alg;
    logic             r_busy;
    logic             r_dest_owner;
    logic             r_frame_valid;
    logic             r_err_invalid;
    logic             r_err_timeout;
    logic             w_start_evt;

    btn_sync_edge u_btn_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_btn   (btn_start),
        .o_pulse (w_start_evt)
    );

    // Run sequencing with registered outputs and the RUN watchdog
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cpu_start   <= 1'b0;
            r_cpu_alg     <= '0;
            r_busy        <= 1'b0;
            r_dest_owner  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_err_invalid <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_evt) begin
                        if (!alg_valid(alg_sel)) begin
                            r_err_invalid <= 1'b1;
                        end else begin
                            r_cpu_alg     <= alg_sel;
                            r_err_invalid <= 1'b0;
                            r_err_timeout <= 1'b0;
                            r_frame_valid <= 1'b0;
                            r_dest_owner  <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= ARM;
                        end
                    end
                end
                ARM: begin
                    // one guard cycle lets the VGA reader's last read retire
                    r_cpu_start <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= RUN;
                end
                RUN: begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    // completion wins over a coincident timeout
                    if (cpu_done) begin
                        r_cpu_start   <= 1'b0;
                        r_frame_valid <= 1'b1;
                        r_state       <= DONE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_cpu_start   <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    r_dest_owner <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_start   = r_cpu_start;
    assign cpu_alg     = r_cpu_alg;
    assign busy        = r_busy;
    assign dest_owner  = r_dest_owner;
    assign frame_valid = r_frame_valid;
    assign err_invalid = r_err_invalid;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_scaler_uc.sv
// Bench for scaler_uc: two instances (default watchdog and a short one)
// share the button, switches and reset; each has its own done input.
module tb_scaler_uc;

    localparam int TO_A = 131072;
    localparam int TO_B = 100;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       btn   = 1'b0;
    logic [1:0] alg   = 2'b00;
    logic       done  [2] = '{1'b0, 1'b0};

    logic       cs    [2];
    logic [1:0] calg  [2];
    logic       busy  [2];
    logic       dst   [2];
    logic       fv    [2];
    logic       einv  [2];
    logic       eto   [2];

    always #5 clk = ~clk;

    scaler_uc #(.TIMEOUT_CYCLES(TO_A), .CNT_W(18)) u_a (
        .clk(clk), .reset(reset), .btn_start(btn), .alg_sel(alg),
        .cpu_done(done[0]), .cpu_start(cs[0]), .cpu_alg(calg[0]),
        .busy(busy[0]), .dest_owner(dst[0]), .frame_valid(fv[0]),
        .err_invalid(einv[0]), .err_timeout(eto[0])
    );

    scaler_uc #(.TIMEOUT_CYCLES(TO_B), .CNT_W(7)) u_b (
        .clk(clk), .reset(reset), .btn_start(btn), .alg_sel(alg),
        .cpu_done(done[1]), .cpu_start(cs[1]), .cpu_alg(calg[1]),
        .busy(busy[1]), .dest_owner(dst[1]), .frame_valid(fv[1]),
        .err_invalid(einv[1]), .err_timeout(eto[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: timestamps of accept and end per instance.
    // A press is seen at edge n when the pin was 1 at edge n-2 and 0 at n-3.
    int         cyc = 0;
    logic [2:0] hist;
    int         m_acc  [2];
    int         m_end  [2];
    bit         m_open [2];
    logic [1:0] m_alg  [2];
    bit         m_fv   [2];
    bit         m_einv [2];
    bit         m_eto  [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist = '0;
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = -10; m_end[i] = -10; m_open[i] = 0;
                m_alg[i] = 2'b00; m_fv[i] = 0; m_einv[i] = 0; m_eto[i] = 0;
            end
        end else begin
            bit evt;
            int lim;
            cyc++;
            evt = hist[1] & ~hist[2];
            for (int i = 0; i < 2; i++) begin
                lim = (i == 0) ? TO_A : TO_B;
                if (m_open[i] && cyc >= m_acc[i] + 2) begin
                    if (done[i]) begin
                        m_open[i] = 0; m_end[i] = cyc; m_fv[i] = 1;
                    end else if (cyc == m_acc[i] + 1 + lim) begin
                        m_open[i] = 0; m_end[i] = cyc; m_eto[i] = 1;
                    end
                end else if (!m_open[i] && cyc >= m_end[i] + 2 && evt) begin
                    if (alg == 2'b11) begin
                        m_einv[i] = 1;
                    end else begin
                        m_acc[i] = cyc; m_open[i] = 1; m_alg[i] = alg;
                        m_einv[i] = 0; m_eto[i] = 0; m_fv[i] = 0;
                    end
                end
            end
            hist = {hist[1:0], btn};
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit e_run;
            e_run = m_open[i] || (cyc == m_end[i]);
            chk($sformatf("cpu_start[%0d]", i), cs[i], int'(m_open[i] && cyc >= m_acc[i] + 1));
            chk($sformatf("busy[%0d]", i), busy[i], int'(e_run));
            chk($sformatf("dest_owner[%0d]", i), dst[i], int'(e_run));
            chk($sformatf("cpu_alg[%0d]", i), calg[i], m_alg[i]);
            chk($sformatf("frame_valid[%0d]", i), fv[i], int'(m_fv[i]));
            chk($sformatf("err_invalid[%0d]", i), einv[i], int'(m_einv[i]));
            chk($sformatf("err_timeout[%0d]", i), eto[i], int'(m_eto[i]));
        end
    end

    // Run counting and cpu_start high-time measurement
    int rise0 = 0;
    bit prev0 = 0;
    int hi_len1 = 0;
    int last_len1 = 0;
    always @(negedge clk) begin
        if (cs[0] && !prev0) rise0++;
        prev0 = cs[0];
        if (cs[1]) hi_len1++;
        else if (hi_len1 != 0) begin
            last_len1 = hi_len1;
            hi_len1 = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_start(input int idx, input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            tick(1);
            if (cs[idx]) begin
                ok = 1;
                break;
            end
        end
        chk($sformatf("wait_start[%0d]", idx), int'(ok), 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            tick(1);
            if (!busy[0] && !busy[1]) begin
                ok = 1;
                break;
            end
        end
        chk("wait_idle", int'(ok), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int r0;
        // reset state
        tick(5);
        chk("rst_busy", busy[0], 0);
        chk("rst_cpu_start", cs[0], 0);
        reset = 1'b1;
        tick(2);

        // normal run, alg 01, 5-cycle press, done after 76800 cycles
        alg = 2'b01;
        btn = 1'b1;
        tick(3);
        chk("arm_dest_owner", dst[0], 1);
        chk("arm_cpu_start", cs[0], 0);
        tick(1);
        chk("run_cpu_start", cs[0], 1);
        chk("run_cpu_alg", calg[0], 1);
        tick(1);
        btn = 1'b0;
        tick(76798);
        done[0] = 1'b1;
        tick(1);
        done[0] = 1'b0;
        chk("done_cpu_start", cs[0], 0);
        chk("done_frame_valid", fv[0], 1);
        chk("done_dest_owner_held", dst[0], 1);
        tick(1);
        chk("idle_dest_owner", dst[0], 0);
        chk("idle_busy", busy[0], 0);
        chk("to_run_length", last_len1, 100);
        chk("to_err_timeout", eto[1], 1);
        chk("to_frame_valid", fv[1], 0);
        chk("to_busy", busy[1], 0);

        // reserved algorithm, then a valid press
        alg = 2'b11;
        btn = 1'b1;
        tick(4);
        btn = 1'b0;
        tick(4);
        chk("inv_err_invalid", einv[0], 1);
        chk("inv_busy", busy[0], 0);
        alg = 2'b00;
        btn = 1'b1;
        wait_start(0, 10);
        btn = 1'b0;
        chk("inv_cleared", einv[0], 0);
        tick(20);
        done[0] = 1'b1;
        tick(1);
        done[0] = 1'b0;
        wait_idle(200);

        // held button, presses and switch changes during the run
        r0 = rise0;
        alg = 2'b10;
        btn = 1'b1;
        wait_start(0, 10);
        alg = 2'b01;
        tick(1000);
        btn = 1'b0;
        tick(100);
        alg = 2'b00;
        btn = 1'b1; tick(3); btn = 1'b0;
        tick(50);
        btn = 1'b1; tick(3); btn = 1'b0;
        tick(200);
        chk("held_cpu_alg", calg[0], 2);
        done[0] = 1'b1;
        tick(1);
        done[0] = 1'b0;
        wait_idle(200);
        chk("held_one_run", rise0 - r0, 1);

        // asynchronous reset 500 cycles into a run
        alg = 2'b01;
        btn = 1'b1;
        wait_start(0, 10);
        btn = 1'b0;
        tick(500);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cpu_start", cs[0], 0);
        chk("arst_dest_owner", dst[0], 0);
        chk("arst_busy", busy[0], 0);
        tick(3);
        reset = 1'b1;
        chk("arst_frame_valid", fv[0], 0);
        alg = 2'b00;
        btn = 1'b1;
        wait_start(0, 10);
        btn = 1'b0;
        tick(10);
        done[0] = 1'b1;
        tick(1);
        done[0] = 1'b0;
        wait_idle(200);

        // done on the same edge as the short watchdog expires
        alg = 2'b01;
        btn = 1'b1;
        wait_start(1, 10);
        btn = 1'b0;
        tick(99);
        done[0] = 1'b1;
        done[1] = 1'b1;
        tick(1);
        done[0] = 1'b0;
        done[1] = 1'b0;
        chk("tie_frame_valid", fv[1], 1);
        chk("tie_err_timeout", eto[1], 0);
        chk("tie_cpu_start", cs[1], 0);
        chk("tie_run_length", last_len1, 100);
        wait_idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
